// File: rtl/rx_pkg.sv
// Shared constants, FSM encoding and instruction decode for the rx command
// path. The rx receiver imports the same package.
package rx_pkg;

    localparam int DATA_W     = 4;
    localparam int INSTR_W    = 4;
    localparam int FRAME_BITS = 10;

    localparam logic [INSTR_W-1:0] INSTR_CLEAN = 4'd1;
    localparam logic [INSTR_W-1:0] INSTR_SHOW  = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        INSTR,
        STOP,
        GAP
    } state_e;

    function automatic logic instr_valid(input logic [INSTR_W-1:0] code);
        return (code == INSTR_CLEAN) || (code == INSTR_SHOW);
    endfunction

endpackage

// File: rtl/rx_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index at or
// after ptr_i, wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o
);

    logic found;
    int   j;

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rx_cmd_scheduler.sv
// Round-robin command scheduler that serializes start/data/instr/stop frames
// onto the idle-high transmission line feeding the rx receiver.
module rx_cmd_scheduler
    import rx_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk2,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [DATA_W*N_REQ-1:0]  req_data,
    input  logic [INSTR_W*N_REQ-1:0] req_instr,
    output logic [N_REQ-1:0]         ack,
    output logic                     reject,
    output logic                     busy,
    output logic                     transmission,
    output logic                     frame_done,
    output logic [7:0]               frame_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SH_W  = DATA_W + INSTR_W;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [1:0]         bit_cnt_q;
    logic [3:0]         gap_cnt_q;
    logic [SH_W-1:0]    frame_q;
    logic [N_REQ-1:0]   ack_q;
    logic               reject_q;
    logic               busy_q;
    logic               tx_q;
    logic               frame_done_q;
    logic [7:0]         frame_count_q;

    logic [N_REQ-1:0]   grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_d;
    logic [DATA_W-1:0]  sel_data;
    logic [INSTR_W-1:0] sel_instr;
    logic               gap_last;
    logic               arb_ok;

    rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_instr = req_instr[int'(grant_idx)*INSTR_W +: INSTR_W];
    assign ptr_d     = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;

    // The last gap cycle doubles as a grant cycle, so the frame period is
    // 10+GAP_CYCLES; ack_q blocks a re-grant in the cycle right after a reject.
    assign gap_last = (state_q == GAP) && (gap_cnt_q == 4'(GAP_CYCLES - 1));
    assign arb_ok   = ((state_q == IDLE) || gap_last) && (|grant) && (ack_q == '0);

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            frame_q       <= '0;
            ack_q         <= '0;
            reject_q      <= 1'b0;
            busy_q        <= 1'b0;
            tx_q          <= 1'b1;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            ack_q        <= '0;
            reject_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                START: begin
                    tx_q      <= 1'b0;
                    bit_cnt_q <= '0;
                    state_q   <= DATA;
                end
                DATA: begin
                    tx_q      <= frame_q[SH_W-1];
                    frame_q   <= {frame_q[SH_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'(DATA_W - 1)) state_q <= INSTR;
                end
                INSTR: begin
                    tx_q      <= frame_q[SH_W-1];
                    frame_q   <= {frame_q[SH_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'(INSTR_W - 1)) state_q <= STOP;
                end
                STOP: begin
                    tx_q          <= 1'b1;
                    frame_done_q  <= 1'b1;
                    frame_count_q <= frame_count_q + 8'd1;
                    gap_cnt_q     <= '0;
                    state_q       <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: begin
                    tx_q      <= 1'b1;
                    gap_cnt_q <= gap_cnt_q + 4'd1;
                    if (gap_last) state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase

            if (arb_ok) begin
                ack_q <= grant;
                ptr_q <= ptr_d;
                if (instr_valid(sel_instr)) begin
                    frame_q <= {sel_data, sel_instr};
                    busy_q  <= 1'b1;
                    state_q <= START;
                end else begin
                    reject_q <= 1'b1;
                end
            end
        end
    end

    assign ack          = ack_q;
    assign reject       = reject_q;
    assign busy         = busy_q;
    assign transmission = tx_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_rx_cmd_scheduler.sv
// Directed bench for rx_cmd_scheduler: one instance with GAP_CYCLES=2 and one
// with GAP_CYCLES=0, sharing clock and reset.
module tb_rx_cmd_scheduler;

    localparam int N = 2;

    logic clk2 = 1'b0;
    logic reset;
    always #5 clk2 = ~clk2;

    logic [N-1:0]   req_a, ack_a, req_b, ack_b;
    logic [4*N-1:0] data_a, instr_a, data_b, instr_b;
    logic           reject_a, busy_a, tx_a, fd_a;
    logic           reject_b, busy_b, tx_b, fd_b;
    logic [7:0]     cnt_a, cnt_b;

    rx_cmd_scheduler #(.N_REQ(N), .GAP_CYCLES(2)) dut_gap2 (
        .clk2(clk2), .reset(reset), .req(req_a), .req_data(data_a),
        .req_instr(instr_a), .ack(ack_a), .reject(reject_a), .busy(busy_a),
        .transmission(tx_a), .frame_done(fd_a), .frame_count(cnt_a)
    );

    rx_cmd_scheduler #(.N_REQ(N), .GAP_CYCLES(0)) dut_gap0 (
        .clk2(clk2), .reset(reset), .req(req_b), .req_data(data_b),
        .req_instr(instr_b), .ack(ack_b), .reject(reject_b), .busy(busy_b),
        .transmission(tx_b), .frame_done(fd_b), .frame_count(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk2);
    endtask

    logic [9:0]  line1, line5a, line5b;
    logic [1:0]  ack_val [4];
    int          ack_cyc [4];
    int          nacks, cyc_n, w, fd_n;

    initial begin
        reset = 1'b1;
        req_a = '0; data_a = '0; instr_a = '0;
        req_b = '0; data_b = '0; instr_b = '0;
        cyc(2);
        check("rst_tx", tx_a, 1'b1);
        check("rst_ack", ack_a, 2'b00);
        check("rst_reject", reject_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_fd", fd_a, 1'b0);
        check("rst_cnt", cnt_a, 8'd0);
        reset = 1'b0;
        cyc(1);

        // Single valid frame: data A, SHOW from requester 0
        data_a = 8'h0A; instr_a = 8'h04; req_a = 2'b01;
        cyc(1);
        check("t1_ack", ack_a, 2'b01);
        check("t1_busy", busy_a, 1'b1);
        check("t1_tx_T", tx_a, 1'b1);
        check("t1_reject", reject_a, 1'b0);
        req_a = 2'b00;
        line1 = 10'b0101001001;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check($sformatf("t1_line_T+%0d", k), tx_a, line1[10-k]);
            if (k == 9) check("t1_fd_early", fd_a, 1'b0);
        end
        check("t1_fd", fd_a, 1'b1);
        check("t1_cnt", cnt_a, 8'd1);
        cyc(1);
        check("t1_fd_off", fd_a, 1'b0);
        check("t1_busy_gap1", busy_a, 1'b1);
        cyc(1);
        check("t1_busy_gap2", busy_a, 1'b1);
        cyc(1);
        check("t1_busy_off", busy_a, 1'b0);

        // Invalid instruction from requester 1
        data_a = 8'h50; instr_a = 8'h30; req_a = 2'b10;
        cyc(1);
        check("t2_ack", ack_a, 2'b10);
        check("t2_reject", reject_a, 1'b1);
        check("t2_busy", busy_a, 1'b0);
        check("t2_tx", tx_a, 1'b1);
        req_a = 2'b00;
        cyc(1);
        check("t2_ack_off", ack_a, 2'b00);
        check("t2_reject_off", reject_a, 1'b0);
        cyc(3);
        check("t2_tx_idle", tx_a, 1'b1);
        check("t2_cnt", cnt_a, 8'd1);

        // Contention: both held, pointer back at 0
        data_a = 8'h21; instr_a = 8'h41; req_a = 2'b11;
        nacks = 0; cyc_n = 0;
        for (int c = 0; c < 80 && nacks < 4; c++) begin
            cyc(1);
            cyc_n++;
            if (ack_a != 2'b00) begin
                ack_val[nacks] = ack_a;
                ack_cyc[nacks] = cyc_n;
                nacks++;
                if (nacks == 4) req_a = 2'b00;
            end
        end
        check("t3_nacks", nacks, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_ack%0d", i), ack_val[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) check($sformatf("t3_space%0d", i), ack_cyc[i] - ack_cyc[i-1], 12);
        end
        w = 0;
        do begin
            cyc(1);
            w++;
        end while (busy_a && w < 40);
        check("t3_idle", busy_a, 1'b0);
        check("t3_cnt", cnt_a, 8'd5);

        // Reset in the middle of DATA
        data_a = 8'h0A; instr_a = 8'h04; req_a = 2'b01;
        cyc(1);
        check("t4_ack", ack_a, 2'b01);
        req_a = 2'b00;
        cyc(5);
        check("t4_tx_T+5", tx_a, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("t4_tx_async", tx_a, 1'b1);
        check("t4_busy", busy_a, 1'b0);
        check("t4_cnt", cnt_a, 8'd0);
        check("t4_ack_rst", ack_a, 2'b00);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        check("t4_tx_idle", tx_a, 1'b1);
        check("t4_no_ack", ack_a, 2'b00);
        check("t4_no_reject", reject_a, 1'b0);
        req_a = 2'b01;
        cyc(1);
        check("t4_ack2", ack_a, 2'b01);
        req_a = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check($sformatf("t4_line_T+%0d", k), tx_a, line1[10-k]);
        end
        check("t4_cnt2", cnt_a, 8'd1);

        // GAP_CYCLES=0, CLEAN then SHOW back to back
        data_b = 8'h53; instr_b = 8'h41; req_b = 2'b11;
        line5a = 10'b0001100011;
        line5b = 10'b0010101001;
        cyc(1);
        check("t5_ack0", ack_b, 2'b01);
        req_b = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check($sformatf("t5_f1_T+%0d", k), tx_b, line5a[10-k]);
        end
        check("t5_fd", fd_b, 1'b1);
        cyc(1);
        check("t5_ack1", ack_b, 2'b10);
        check("t5_idle_tx", tx_b, 1'b1);
        req_b = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check($sformatf("t5_f2_T+%0d", k + 11), tx_b, line5b[10-k]);
        end
        check("t5_cnt", cnt_b, 8'd2);

        // 256 frames wrap frame_count
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_cnt_rst", cnt_b, 8'd0);
        data_b = 8'h07; instr_b = 8'h01; req_b = 2'b01;
        fd_n = 0;
        for (int c = 0; c < 256*11 + 40 && fd_n < 256; c++) begin
            cyc(1);
            if (fd_b) begin
                fd_n++;
                if (fd_n == 255) check("t6_cnt255", cnt_b, 8'd255);
            end
        end
        req_b = 2'b00;
        check("t6_fd_pulses", fd_n, 256);
        check("t6_cnt_wrap", cnt_b, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
